prange: RTL
===========

# prange

Parametrised lane-parallel range generator, the next generation of the single-value `range`/`hrange` generator cores. It emits up to `LANES` range values per beat with a per-lane valid mask, supports ascending and descending steps, and terminates safely at the `WIDTH`-bit arithmetic limit instead of wrapping. It sits behind the same `_start`/`_ready`/`_valid`/`_done` generator handshake as the other generated cores, so the existing testbench flow drives it unchanged apart from lane unpacking.

## Interface
- `WIDTH`, 32, signed data width of `base`, `limit`, `step` and each output lane.
- `LANES`, 2, values emitted per beat (≥1).
- `_clock` in 1: single clock, rising edge.
- `_reset` in 1: synchronous, active-high reset.
- `_start` in 1: sample arguments and begin a sequence.
- `_ready` in 1: consumer can accept the current beat.
- `base` in WIDTH signed: first value; sampled only on the `_start` cycle.
- `limit` in WIDTH signed: exclusive bound; sampled only on the `_start` cycle.
- `step` in WIDTH signed: increment; sampled only on the `_start` cycle.
- `_done` out 1: idle, or sequence finished.
- `_valid` out 1: current beat holds at least one value.
- `_outs` out LANES*WIDTH signed: lane k occupies bits [k*WIDTH +: WIDTH].
- `_mask` out LANES: bit k set when lane k holds a value; valid lanes are always contiguous from lane 0.

## Operation
- Sequence semantics match Python `range(base, limit, step)`:
  - for step>0, value v is in range iff v<limit;
  - for step<0, v is in range iff v>limit;
  - step==0 gives an empty sequence, not an error.
- Lane values: lane k = cur + k*step.
- Each lane's sum is computed in WIDTH+2 bits. A lane whose exact value leaves the signed WIDTH range is out of range, and so is every later lane; there is no wrap-around.
- States:
  - IDLE: `_done`=1, `_valid`=0.
  - RUN: `_done`=0.
- Transitions:
  - IDLE→RUN: `_start`=1 and lane 0 (base) is in range. Captures `base`, `limit`, `step`.
  - IDLE→IDLE: `_start`=1 with an empty sequence (step 0, or base already past limit). `_done` pulses low for one cycle, then returns high.
  - RUN→RUN (advance): `_valid`&&`_ready` and the next beat is non-empty. cur += LANES*step, computed overflow-checked.
  - RUN→IDLE: `_valid`&&`_ready` and the next beat is empty, or the advance overflows.
  - RUN with `_start`=1: abort. Arguments are recaptured and the sequence restarts from the new `base`. The current beat is discarded whether or not it was accepted.
- Backpressure: while `_valid`&&!`_ready`, `_outs`, `_mask` and `_valid` hold stable.

## Timing
- Reset values: `_done`=1, `_valid`=0, `_outs`=0, `_mask`=0, state=IDLE.
- `_reset` has priority over `_start` and also aborts a sequence mid-run; there is no residual output.
- Latency: first beat is valid on the cycle after the `_start` edge.
- Throughput: one beat per cycle while `_ready`=1.
- `_done` rises the cycle after the last beat is accepted. On that cycle `_valid`=0 and `_mask`=0, and `_outs` holds its last value.
- `_valid` is never asserted with `_mask`=0.
- `_done` and `_valid` are never both 1.

## Structure
- `prange_pkg` holds:
  - the state enum (IDLE, RUN);
  - the `in_range(v, limit, step_sign)` function;
  - the WIDTH+2 guard-width constant.
- Sub-module `prange_lane_calc`: combinational. Given cur, step and limit, it produces lane values, the contiguous mask, and the next-beat-empty and overflow flags.
- `prange` wraps the lane calculator with the FSM and registered outputs.

## Test plan
- WIDTH=32, LANES=2, (1,11,3), `_ready`=1 → beats {1,4} mask 11, then {7,10} mask 11, then `_done`=1 next cycle.
- (0,10,2) → beats {0,2} 11, {4,6} 11, {8,–} 01, then `_done`. Run twice back-to-back with identical results.
- Descending (10,0,-3) → {10,7} 11, {4,1} 11, then done. Also (0,10,-1) and step 0 → no `_valid` ever, `_done` low for exactly one cycle.
- Backpressure on (0,10,2): drop `_ready` for 3 cycles during beat {4,6} → outputs held unchanged, no value lost or duplicated, total of 5 values.
- WIDTH=8, LANES=2, (120,127,5) → beat {120,125} mask 11, then `_done`; 130 must not wrap to -126.
- Abort cases on (0,100,1):
  - `_start` with (50,52,1) mid-run → next beat {50,51}, then done.
  - `_reset` mid-run → `_valid`=0 and `_done`=1 the next cycle.

Source files
------------

// File: rtl/prange_pkg.sv
// Shared definitions for the lane-parallel range generator: state encoding,
// guard-width constant and the direction-aware range test.
package prange_pkg;

    localparam int GUARD_BITS = 2;
    localparam int RANGE_W    = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Caller sign-extends both operands to RANGE_W; step==0 is handled by the caller.
    function automatic logic in_range(input logic signed [RANGE_W-1:0] v,
                                      input logic signed [RANGE_W-1:0] limit,
                                      input logic                      step_neg);
        return step_neg ? (v > limit) : (v < limit);
    endfunction

endpackage

// File: rtl/prange_lane_calc.sv
// Combinational beat calculator: lane values, contiguous valid mask and the
// look-ahead flags for the beat that would follow this one.
module prange_lane_calc
    import prange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic signed [WIDTH-1:0]       cur,
    input  logic signed [WIDTH-1:0]       step,
    input  logic signed [WIDTH-1:0]       limit,
    output logic        [LANES*WIDTH-1:0] lanes,
    output logic        [LANES-1:0]       mask,
    output logic signed [WIDTH-1:0]       next_cur,
    output logic                          next_empty,
    output logic                          overflow
);

    localparam int GW = WIDTH + GUARD_BITS;

    logic signed [GW-1:0] sum [LANES+1];
    logic signed [GW-1:0] step_ext;
    logic signed [RANGE_W-1:0] limit_ext;
    logic step_neg;
    logic step_zero;

    function automatic logic fits(input logic signed [GW-1:0] v);
        return (v[GW-1:WIDTH-1] == '0) || (v[GW-1:WIDTH-1] == '1);
    endfunction

    // Lanes are chained one step apart, so each add stays within the guard width
    // as long as the previous lane was representable; later garbage is masked off.
    always_comb begin
        logic prev;
        step_ext  = {{GUARD_BITS{step[WIDTH-1]}}, step};
        limit_ext = RANGE_W'(limit);
        step_neg  = step[WIDTH-1];
        step_zero = (step == '0);
        sum[0]    = {{GUARD_BITS{cur[WIDTH-1]}}, cur};
        for (int k = 1; k <= LANES; k++) begin
            sum[k] = sum[k-1] + step_ext;
        end

        lanes = '0;
        mask  = '0;
        prev  = !step_zero;
        for (int k = 0; k < LANES; k++) begin
            lanes[k*WIDTH +: WIDTH] = sum[k][WIDTH-1:0];
            mask[k] = prev && fits(sum[k]) && in_range(RANGE_W'(sum[k]), limit_ext, step_neg);
            prev    = mask[k];
        end

        overflow   = !fits(sum[LANES]);
        next_cur   = sum[LANES][WIDTH-1:0];
        next_empty = !mask[LANES-1] || overflow ||
                     !in_range(RANGE_W'(sum[LANES]), limit_ext, step_neg);
    end

endmodule

// File: rtl/prange.sv
// Lane-parallel range generator: FSM and registered beat around prange_lane_calc,
// driven through the standard _start/_ready/_valid/_done generator handshake.
module prange
    import prange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic                          _clock,
    input  logic                          _reset,
    input  logic                          _start,
    input  logic                          _ready,
    input  logic signed [WIDTH-1:0]       base,
    input  logic signed [WIDTH-1:0]       limit,
    input  logic signed [WIDTH-1:0]       step,
    output logic                          _done,
    output logic                          _valid,
    output logic signed [LANES*WIDTH-1:0] _outs,
    output logic        [LANES-1:0]       _mask
);

    state_e state;
    logic done_q;
    logic more_q;
    logic signed [WIDTH-1:0] cur_q;
    logic signed [WIDTH-1:0] step_q;
    logic signed [WIDTH-1:0] limit_q;
    logic [LANES*WIDTH-1:0] outs_q;
    logic [LANES-1:0] mask_q;

    logic signed [WIDTH-1:0] calc_cur;
    logic signed [WIDTH-1:0] calc_step;
    logic signed [WIDTH-1:0] calc_limit;
    logic [LANES*WIDTH-1:0] calc_lanes;
    logic [LANES-1:0] calc_mask;
    logic signed [WIDTH-1:0] calc_next;
    logic calc_next_empty;
    logic calc_overflow;

    // cur_q always holds the first value of the beat after the one on the outputs,
    // so the calculator precomputes whatever gets loaded on the next accept.
    assign calc_cur   = _start ? base  : cur_q;
    assign calc_step  = _start ? step  : step_q;
    assign calc_limit = _start ? limit : limit_q;

    prange_lane_calc #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_calc (
        .cur        (calc_cur),
        .step       (calc_step),
        .limit      (calc_limit),
        .lanes      (calc_lanes),
        .mask       (calc_mask),
        .next_cur   (calc_next),
        .next_empty (calc_next_empty),
        .overflow   (calc_overflow)
    );

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state   <= ST_IDLE;
            done_q  <= 1'b1;
            more_q  <= 1'b0;
            cur_q   <= '0;
            step_q  <= '0;
            limit_q <= '0;
            outs_q  <= '0;
            mask_q  <= '0;
        end else if (_start) begin
            step_q  <= step;
            limit_q <= limit;
            done_q  <= 1'b0;
            if (calc_mask[0]) begin
                state  <= ST_RUN;
                outs_q <= calc_lanes;
                mask_q <= calc_mask;
                cur_q  <= calc_next;
                more_q <= !calc_next_empty && !calc_overflow;
            end else begin
                // Empty sequence: stay idle but drop _done for one cycle.
                state  <= ST_IDLE;
                mask_q <= '0;
                more_q <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            if (_ready) begin
                if (more_q) begin
                    outs_q <= calc_lanes;
                    mask_q <= calc_mask;
                    cur_q  <= calc_next;
                    more_q <= !calc_next_empty && !calc_overflow;
                end else begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                    mask_q <= '0;
                end
            end
        end else begin
            done_q <= 1'b1;
        end
    end

    assign _valid = (state == ST_RUN);
    assign _done  = done_q;
    assign _outs  = outs_q;
    assign _mask  = mask_q;

endmodule
